aux_dac: RTL and testbench

AUX_DAC -- requirements
Module: aux_dac

---
 rtl/aux_dac.sv | 62 ++++++
 tb/tb_aux_dac.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/aux_dac.sv
// NES APU non-linear mixing DAC: pulse and TND sums mapped through constant level tables.
// Latency 1 clock, a new sample accepted every cycle, no backpressure.
module aux_dac (
  input  logic        CLK,
  input  logic        RES,
  input  logic [7:0]  AUX_A,
  input  logic [14:0] AUX_B,
  input  logic [23:0] ADDR,
  output logic [31:0] AOut,
  output logic [31:0] BOut,
  output logic [23:0] ADDR_Q
);

  // Elaboration-time table builders; floor(x + 0.5) gives round-half-up for positive levels.
  function automatic logic [31:0] pulse_code(input int idx);
    real lvl;
    if (idx == 0) return 32'd0;
    lvl = 95.52 / (8128.0 / real'(idx) + 100.0);
    return 32'(longint'($floor(lvl * 4294967296.0 + 0.5)));
  endfunction

  function automatic logic [31:0] tnd_code(input int idx);
    real lvl;
    if (idx == 0) return 32'd0;
    lvl = 163.67 / (24329.0 / real'(idx) + 100.0);
    return 32'(longint'($floor(lvl * 4294967296.0 + 0.5)));
  endfunction

  logic [31:0] pulse_tab [31];
  logic [31:0] tnd_tab   [203];

  for (genvar g = 0; g < 31; g++) begin : g_pulse
    localparam logic [31:0] CODE = pulse_code(g);
    assign pulse_tab[g] = CODE;
  end

  for (genvar g = 0; g < 203; g++) begin : g_tnd
    localparam logic [31:0] CODE = tnd_code(g);
    assign tnd_tab[g] = CODE;
  end

  logic [4:0] pi;
  logic [7:0] ti;

  // Maximum sums are 30 and 202, so both indices always land inside their tables.
  assign pi = {1'b0, AUX_A[3:0]} + {1'b0, AUX_A[7:4]};
  assign ti = {4'd0, AUX_B[3:0]} + {3'd0, AUX_B[3:0], 1'b0}
            + {3'd0, AUX_B[7:4], 1'b0} + {1'b0, AUX_B[14:8]};

  always_ff @(posedge CLK) begin
    if (RES) begin
      AOut   <= 32'd0;
      BOut   <= 32'd0;
      ADDR_Q <= 24'd0;
    end else begin
      AOut   <= pulse_tab[pi];
      BOut   <= tnd_tab[ti];
      ADDR_Q <= ADDR;
    end
  end

endmodule

// File: tb/tb_aux_dac.sv
// Randomized and sweep stimulus for aux_dac, checked every cycle against a formula-level model.
module tb_aux_dac;

  logic        clk;
  logic        res;
  logic [7:0]  aux_a;
  logic [14:0] aux_b;
  logic [23:0] addr;
  logic [31:0] aout;
  logic [31:0] bout;
  logic [23:0] addr_q;

  int checks = 0;
  int errors = 0;

  aux_dac dut (
    .CLK(clk), .RES(res), .AUX_A(aux_a), .AUX_B(aux_b), .ADDR(addr),
    .AOut(aout), .BOut(bout), .ADDR_Q(addr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference levels straight from the mixer formulas.
  function automatic longint p_ref(input int s1, input int s2);
    int  idx;
    real lvl;
    idx = s1 + s2;
    if (idx == 0) return 0;
    lvl = 95.52 / (8128.0 / real'(idx) + 100.0);
    return longint'($floor(lvl * 4294967296.0 + 0.5));
  endfunction

  function automatic longint t_ref(input int tri_c, input int noi, input int dmc);
    int  idx;
    real lvl;
    idx = 3 * tri_c + 2 * noi + dmc;
    if (idx == 0) return 0;
    lvl = 163.67 / (24329.0 / real'(idx) + 100.0);
    return longint'($floor(lvl * 4294967296.0 + 0.5));
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Model: what the outputs must show after each rising edge.
  longint exp_a, exp_b, exp_q;
  bit     model_vld = 1'b0;
  bit     run_cmp   = 1'b1;

  always @(posedge clk) begin
    if (res) begin
      exp_a = 0; exp_b = 0; exp_q = 0;
      model_vld = 1'b1;
    end else if (model_vld) begin
      exp_a = p_ref(int'(aux_a[3:0]), int'(aux_a[7:4]));
      exp_b = t_ref(int'(aux_b[3:0]), int'(aux_b[7:4]), int'(aux_b[14:8]));
      exp_q = longint'(addr);
    end
  end

  always @(negedge clk) begin
    if (model_vld && run_cmp) begin
      check("aout_track", longint'(aout), exp_a);
      check("bout_track", longint'(bout), exp_b);
      check("addr_q_track", longint'(addr_q), exp_q);
    end
  end

  task automatic drive(input logic [7:0] a, input logic [14:0] b, input logic [23:0] ad,
                       input logic r);
    aux_a = a; aux_b = b; addr = ad; res = r;
    @(posedge clk);
    #2;
  endtask

  longint pin_p1, pin_p30, pin_t202, prev;

  initial begin
    aux_a = 8'hFF; aux_b = 15'h7FFF; addr = 24'hABCDEF; res = 1'b1;
    #2;

    // Reset holds outputs at zero whatever the inputs.
    drive(8'hFF, 15'h7FFF, 24'hABCDEF, 1'b1);
    drive(8'hFF, 15'h7FFF, 24'hABCDEF, 1'b1);
    check("reset_aout", longint'(aout), 0);
    check("reset_bout", longint'(bout), 0);
    check("reset_addr_q", longint'(addr_q), 0);

    // Exact rational pins: 95.52/8228, 2865.6/11128, 33061.34/44529.
    pin_p1   = (longint'(64'd4294967296) * 9552 + 411400) / 822800;
    pin_p30  = (longint'(64'd4294967296) * 286560 + 556400) / 1112800;
    pin_t202 = (longint'(64'd4294967296) * 3306134 + 2226450) / 4452900;
    check("model_p1", p_ref(1, 0), pin_p1);
    check("model_p30", p_ref(15, 15), pin_p30);
    check("model_t202", t_ref(15, 15, 127), pin_t202);

    prev = -1;
    for (int i = 0; i <= 30; i++) begin
      if (p_ref(i, 0) <= prev) check("model_p_mono", p_ref(i, 0), prev + 1);
      prev = (i <= 15) ? p_ref(i, 0) : p_ref(15, i - 15);
    end
    prev = -1;
    for (int i = 0; i <= 202; i++) begin
      longint v;
      v = t_ref(0, 0, 0) + 0;
      v = (i <= 127) ? t_ref(0, 0, i) : t_ref(0, 0, 127) * 0 + t_ref((i - 127 + 2) / 3, 0, i - 3 * ((i - 127 + 2) / 3));
      if (v <= prev) check("model_t_mono", v, prev + 1);
      prev = v;
    end

    // First sample after reset, one clock later.
    drive(8'h00, 15'h0000, 24'd5, 1'b0);
    check("zero_aout", longint'(aout), 0);
    check("zero_bout", longint'(bout), 0);
    check("zero_addr_q", longint'(addr_q), 5);

    drive(8'h01, 15'h0000, 24'd6, 1'b0);
    check("p1_aout", longint'(aout), pin_p1);
    drive(8'h10, 15'h0000, 24'd7, 1'b0);
    check("p1_swapped_aout", longint'(aout), pin_p1);

    drive(8'hFF, 15'h7FFF, 24'hFFFFFF, 1'b0);
    check("pmax_aout", longint'(aout), pin_p30);
    check("tmax_bout", longint'(bout), pin_t202);
    check("addr_q_max", longint'(addr_q), 24'hFFFFFF);

    // Independence: change only B, A output must not move.
    drive(8'hFF, 15'h0123, 24'h000000, 1'b0);
    check("a_indep", longint'(aout), pin_p30);
    check("addr_q_wrap", longint'(addr_q), 0);

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 2000; i++) begin
      drive(8'($urandom), 15'($urandom), 24'($urandom),
            ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

    // Wrapping sweep with a single-cycle reset in the middle.
    aux_a = 8'hF0; aux_b = 15'h7F00; addr = 24'hFFFF00;
    for (int i = 0; i < 600; i++) begin
      drive(aux_a + 8'd1, aux_b + 15'd1, addr + 24'd1, (i == 300) ? 1'b1 : 1'b0);
      if (i == 300) begin
        check("sweep_reset_aout", longint'(aout), 0);
        check("sweep_reset_bout", longint'(bout), 0);
        check("sweep_reset_addr_q", longint'(addr_q), 0);
      end
      if (i == 301) check("sweep_resume_addr_q", longint'(addr_q), longint'(addr));
    end

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
